// File: rtl/axil_pkg.sv
// Shared constants, state encoding and the byte-enable merge helper for the
// AXI4-Lite register bank.
package axil_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         REG_BYTES   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_W  = 3'd1,
    ST_WAIT_AW = 3'd2,
    ST_WCOMMIT = 3'd3,
    ST_BRESP   = 3'd4,
    ST_RLAT    = 3'd5,
    ST_RRESP   = 3'd6
  } axil_state_e;

  // Replace each byte of old_v whose strobe is set with the matching byte of new_v
  function automatic logic [31:0] strb_merge(input logic [31:0]          old_v,
                                             input logic [31:0]          new_v,
                                             input logic [REG_BYTES-1:0] strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < REG_BYTES; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axil_slave_fsm.sv
// AXI4-Lite slave handshake engine: one transaction at a time, captures
// address/data and tells the register bank when to commit or load read data.
module axil_slave_fsm
  import axil_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [REG_BYTES-1:0] wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [ADDR_W-1:0]    araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic                 rvalid,
  input  logic                 rready,
  output logic                 wr_commit,
  output logic [ADDR_W-3:0]    wr_idx,
  output logic [31:0]          wr_data,
  output logic [REG_BYTES-1:0] wr_strb,
  output logic                 rd_load,
  output logic [ADDR_W-3:0]    rd_idx
);

  axil_state_e state_r, state_nx_s;
  logic [ADDR_W-3:0]    waddr_r, raddr_r;
  logic [31:0]          wdata_r;
  logic [REG_BYTES-1:0] wstrb_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state and ready decode; a pending write blocks AR acceptance in IDLE
  always_comb begin
    state_nx_s = state_r;
    awready    = 1'b0;
    wready     = 1'b0;
    arready    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        arready = ~awvalid & ~wvalid;
        if (awvalid && wvalid) begin
          state_nx_s = ST_WCOMMIT;
        end else if (awvalid) begin
          state_nx_s = ST_WAIT_W;
        end else if (wvalid) begin
          state_nx_s = ST_WAIT_AW;
        end else if (arvalid) begin
          state_nx_s = ST_RLAT;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_WAIT_W: begin
        wready = 1'b1;
        if (wvalid) state_nx_s = ST_WCOMMIT;
        else        state_nx_s = ST_WAIT_W;
      end
      ST_WAIT_AW: begin
        awready = 1'b1;
        if (awvalid) state_nx_s = ST_WCOMMIT;
        else         state_nx_s = ST_WAIT_AW;
      end
      ST_WCOMMIT: state_nx_s = ST_BRESP;
      ST_BRESP: begin
        if (bready) state_nx_s = ST_IDLE;
        else        state_nx_s = ST_BRESP;
      end
      ST_RLAT: state_nx_s = ST_RRESP;
      ST_RRESP: begin
        if (rready) state_nx_s = ST_IDLE;
        else        state_nx_s = ST_RRESP;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Capture address and data on their accepting edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_r <= '0;
      raddr_r <= '0;
      wdata_r <= 32'h0;
      wstrb_r <= '0;
    end else begin
      if (awvalid && awready) waddr_r <= awaddr[ADDR_W-1:2];
      if (wvalid && wready) begin
        wdata_r <= wdata;
        wstrb_r <= wstrb;
      end
      if (arvalid && arready) raddr_r <= araddr[ADDR_W-1:2];
    end
  end

  assign bvalid    = (state_r == ST_BRESP);
  assign rvalid    = (state_r == ST_RRESP);
  assign wr_commit = (state_r == ST_WCOMMIT);
  assign rd_load   = (state_r == ST_RLAT);
  assign wr_idx    = waddr_r;
  assign wr_data   = wdata_r;
  assign wr_strb   = wstrb_r;
  assign rd_idx    = raddr_r;

endmodule

// File: rtl/axil_reg_bank.sv
// AXI4-Lite register bank: NUM_REGS 32-bit RW/RO registers with byte strobes,
// SLVERR on bad accesses, per-register commit pulses and self-clearing bits of reg 0.
module axil_reg_bank
  import axil_pkg::*;
#(
  parameter int                  NUM_REGS = 8,
  parameter int                  ADDR_W   = 12,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [31:0]         SC_MASK  = 32'h0
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]      S_AXI_AWADDR,
  input  logic                   S_AXI_AWVALID,
  output logic                   S_AXI_AWREADY,
  input  logic [31:0]            S_AXI_WDATA,
  input  logic [REG_BYTES-1:0]   S_AXI_WSTRB,
  input  logic                   S_AXI_WVALID,
  output logic                   S_AXI_WREADY,
  output logic [1:0]             S_AXI_BRESP,
  output logic                   S_AXI_BVALID,
  input  logic                   S_AXI_BREADY,
  input  logic [ADDR_W-1:0]      S_AXI_ARADDR,
  input  logic                   S_AXI_ARVALID,
  output logic                   S_AXI_ARREADY,
  output logic [31:0]            S_AXI_RDATA,
  output logic [1:0]             S_AXI_RRESP,
  output logic                   S_AXI_RVALID,
  input  logic                   S_AXI_RREADY,
  output logic [32*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]    reg_wr_pulse,
  input  logic [32*NUM_REGS-1:0] status_in
);

  localparam int AIW = ADDR_W - 2;

  logic                 wr_commit_s, rd_load_s;
  logic [AIW-1:0]       wr_idx_s, rd_idx_s;
  logic [31:0]          wr_data_s;
  logic [REG_BYTES-1:0] wr_strb_s;
  logic [NUM_REGS-1:0]  wr_hit_s, rd_hit_s;
  logic                 wr_ok_s;
  logic [31:0]          rd_val_s;
  logic [1:0]           rd_resp_s;

  logic [31:0]          regs_r [NUM_REGS];
  logic [NUM_REGS-1:0]  pulse_r;
  logic [1:0]           bresp_r, rresp_r;
  logic [31:0]          rdata_r;

  axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .awaddr    (S_AXI_AWADDR),
    .awvalid   (S_AXI_AWVALID),
    .awready   (S_AXI_AWREADY),
    .wdata     (S_AXI_WDATA),
    .wstrb     (S_AXI_WSTRB),
    .wvalid    (S_AXI_WVALID),
    .wready    (S_AXI_WREADY),
    .bvalid    (S_AXI_BVALID),
    .bready    (S_AXI_BREADY),
    .araddr    (S_AXI_ARADDR),
    .arvalid   (S_AXI_ARVALID),
    .arready   (S_AXI_ARREADY),
    .rvalid    (S_AXI_RVALID),
    .rready    (S_AXI_RREADY),
    .wr_commit (wr_commit_s),
    .wr_idx    (wr_idx_s),
    .wr_data   (wr_data_s),
    .wr_strb   (wr_strb_s),
    .rd_load   (rd_load_s),
    .rd_idx    (rd_idx_s)
  );

  // One-hot index decode; an out-of-range index hits nothing
  always_comb begin
    wr_hit_s = '0;
    rd_hit_s = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_hit_s[i] = (wr_idx_s == AIW'(i));
      rd_hit_s[i] = (rd_idx_s == AIW'(i));
    end
    wr_ok_s = (|wr_hit_s) & ~(|(wr_hit_s & RO_MASK));
  end

  // Read mux: RO registers return status_in, missing registers return 0 with SLVERR
  always_comb begin
    rd_val_s = 32'h0;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_val_s = rd_val_s |
                 (rd_hit_s[i] ? (RO_MASK[i] ? status_in[32*i +: 32] : regs_r[i]) : 32'h0);
    end
    rd_resp_s = (|rd_hit_s) ? RESP_OKAY : RESP_SLVERR;
  end

  // Register storage, commit pulses and write response
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'h0;
      pulse_r <= '0;
      bresp_r <= RESP_OKAY;
    end else begin
      pulse_r <= '0;
      if (wr_commit_s) begin
        bresp_r <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (wr_ok_s && wr_hit_s[i]) begin
            regs_r[i]  <= strb_merge(regs_r[i], wr_data_s, wr_strb_s);
            pulse_r[i] <= 1'b1;
          end
        end
      end
      // Kick bits live for the single pulse cycle after a commit to reg 0
      if (pulse_r[0]) regs_r[0] <= regs_r[0] & ~SC_MASK;
    end
  end

  // Read data/response held from RLAT until the RREADY handshake
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rdata_r <= 32'h0;
      rresp_r <= RESP_OKAY;
    end else if (rd_load_s) begin
      rdata_r <= rd_val_s;
      rresp_r <= rd_resp_s;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[32*g +: 32] = regs_r[g];
  end

  assign reg_wr_pulse = pulse_r;
  assign S_AXI_BRESP  = bresp_r;
  assign S_AXI_RDATA  = rdata_r;
  assign S_AXI_RRESP  = rresp_r;

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed self-checking bench for axil_reg_bank (8 regs, reg 7 read-only,
// bits 2:1 of reg 0 self-clearing).
module tb_axil_reg_bank;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [11:0]  awaddr, araddr;
  logic         awvalid, awready, wvalid, wready;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic         bvalid, bready, arvalid, arready, rvalid, rready;
  logic [255:0] reg_out, status_in;
  logic [7:0]   reg_wr_pulse;

  int total = 0;
  int bad   = 0;

  logic [1:0]  resp_v;
  logic [7:0]  pulse_v;
  logic [31:0] data_v;

  always #5 clk = ~clk;

  axil_reg_bank #(
    .NUM_REGS (8),
    .ADDR_W   (12),
    .RO_MASK  (8'h80),
    .SC_MASK  (32'h0000_0006)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse),
    .status_in     (status_in)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write with AW and W presented together; returns BRESP and the pulse seen with BVALID
  task automatic axi_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [7:0] pulse);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("wr_bvalid_seen", bvalid, 1'b1);
    resp = bresp; pulse = reg_wr_pulse;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("rd_rvalid_seen", rvalid, 1'b1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    awaddr = 12'h0; araddr = 12'h0; wdata = 32'h0; wstrb = 4'h0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    status_in = {32'h0000_CAFE, 224'd0};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_reg_out", reg_out, 256'd0);
    chk("rst_pulse", reg_wr_pulse, 8'h00);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_readies", {awready, wready, arready}, 3'b111);

    // AW+W together to reg 1 with cycle-exact latency
    @(posedge clk); #1;
    awaddr = 12'h004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    chk("w1_accept", {awready, wready}, 2'b11);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("w1_commit_bvalid", bvalid, 1'b0);
    chk("w1_commit_pulse", reg_wr_pulse, 8'h00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w1_bvalid", bvalid, 1'b1);
    chk("w1_bresp", bresp, 2'b00);
    chk("w1_reg1", reg_out[63:32], 32'hDEAD_BEEF);
    chk("w1_pulse", reg_wr_pulse, 8'b0000_0010);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("w1_pulse_gone", reg_wr_pulse, 8'h00);
    chk("w1_bvalid_gone", bvalid, 1'b0);
    @(posedge clk); #1;
    axi_read(12'h004, data_v, resp_v);
    chk("r1_data", data_v, 32'hDEAD_BEEF);
    chk("r1_resp", resp_v, 2'b00);

    // W three cycles ahead of AW, partial strobes, BREADY held off
    axi_write(12'h004, 32'h1122_3344, 4'hF, resp_v, pulse_v);
    wdata = 32'hAABB_CCDD; wstrb = 4'h5; wvalid = 1'b1;
    @(negedge clk);
    chk("w2_idle_ready", {awready, wready, arready}, 3'b110);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(negedge clk);
    chk("w2_wait_aw_ready", {awready, wready, bvalid}, 3'b100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    awaddr = 12'h004; awvalid = 1'b1;
    @(posedge clk); #1;
    awvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("w2_bvalid", bvalid, 1'b1);
    chk("w2_reg1", reg_out[63:32], 32'h11BB_33DD);
    chk("w2_pulse", reg_wr_pulse, 8'b0000_0010);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("w2_bvalid_hold", bvalid, 1'b1);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("w2_bvalid_gone", bvalid, 1'b0);
    @(posedge clk); #1;

    // Out-of-range and read-only accesses
    axi_write(12'h020, 32'h1234_5678, 4'hF, resp_v, pulse_v);
    chk("oor_bresp", resp_v, 2'b10);
    chk("oor_pulse", pulse_v, 8'h00);
    axi_write(12'h01C, 32'h1234_5678, 4'hF, resp_v, pulse_v);
    chk("ro_bresp", resp_v, 2'b10);
    chk("ro_pulse", pulse_v, 8'h00);
    chk("ro_reg_out", reg_out, {192'd0, 32'h11BB_33DD, 32'h0});
    axi_read(12'h01C, data_v, resp_v);
    chk("ro_rdata", data_v, 32'h0000_CAFE);
    chk("ro_rresp", resp_v, 2'b00);
    axi_read(12'h020, data_v, resp_v);
    chk("oor_rdata", data_v, 32'h0);
    chk("oor_rresp", resp_v, 2'b10);

    // Zero strobes on a legal register: OKAY, pulse, no change
    axi_write(12'h004, 32'hFFFF_FFFF, 4'h0, resp_v, pulse_v);
    chk("zstrb_bresp", resp_v, 2'b00);
    chk("zstrb_pulse", pulse_v, 8'b0000_0010);
    chk("zstrb_reg1", reg_out[63:32], 32'h11BB_33DD);

    // Self-clearing bits of reg 0
    axi_write(12'h000, 32'h0000_0007, 4'hF, resp_v, pulse_v);
    chk("sc_pulse", pulse_v, 8'b0000_0001);
    @(negedge clk);
    chk("sc_reg0_after", reg_out[31:0], 32'h0000_0001);
    chk("sc_no_pulse", reg_wr_pulse, 8'h00);
    @(posedge clk); #1;
    axi_read(12'h000, data_v, resp_v);
    chk("sc_read", data_v, 32'h0000_0001);

    // Write and read presented together: write wins, read follows
    awaddr = 12'h008; wdata = 32'h55AA_55AA; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 12'h004; arvalid = 1'b1;
    @(negedge clk);
    chk("coll_arready", {awready, arready}, 2'b10);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("coll_commit_arready", arready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("coll_bvalid", bvalid, 1'b1);
    chk("coll_reg2", reg_out[95:64], 32'h55AA_55AA);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("coll_ar_now_ready", arready, 1'b1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("coll_rvalid", rvalid, 1'b1);
    chk("coll_rdata", rdata, 32'h11BB_33DD);

    // Asynchronous reset while RVALID is pending
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rvalid", rvalid, 1'b0);
    chk("arst_reg_out", reg_out, 256'd0);
    chk("arst_rdata", rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(12'h008, data_v, resp_v);
    chk("post_rst_reg2", data_v, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
